// File: rtl/ds_pkg.sv
// ds_pkg
// Shared definitions for the downsampling job sequencer slice.
// Provides the phase encoding used on the sequencer's phase output and the
// select input of the BRAM port mux, plus default bus widths.
// No ports (package).

package ds_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    // Phase encoding is visible on the top-level phase output, so the
    // numeric values are fixed and must not be reordered.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LOAD = 2'd1,
        PH_PROC = 2'd2,
        PH_DUMP = 2'd3
    } phase_t;

endpackage

// File: rtl/bram_port_mux.sv
// bram_port_mux
// Registered 3-way mux for the single BRAM address/write port. The active
// phase picks which requester (Rx loader, downsampler core, retriever)
// drives the port; IDLE and DUMP never write.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_sel                     current phase (ds_pkg::phase_t encoding)
//   i_flush                   forces an idle (no-write) cycle, used on abort
//   i_rx_addr/wen/wdata       loader request
//   i_proc_addr/wen/wdata     core request
//   i_ret_addr                retriever read address
//   o_bram_addr/wen/wdata     registered BRAM port

module bram_port_mux
    import ds_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_sel,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_rx_addr,
    input  logic              i_rx_wen,
    input  logic [DATA_W-1:0] i_rx_wdata,
    input  logic [ADDR_W-1:0] i_proc_addr,
    input  logic              i_proc_wen,
    input  logic [DATA_W-1:0] i_proc_wdata,
    input  logic [ADDR_W-1:0] i_ret_addr,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_wen,
    output logic [DATA_W-1:0] o_bram_wdata
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;

    // A flush behaves like reset for one cycle so an aborting phase can
    // never leave a write in flight on the transition edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (i_sel)
                PH_LOAD: begin
                    r_addr  <= i_rx_addr;
                    r_wen   <= i_rx_wen;
                    r_wdata <= i_rx_wdata;
                end
                PH_PROC: begin
                    r_addr  <= i_proc_addr;
                    r_wen   <= i_proc_wen;
                    r_wdata <= i_proc_wdata;
                end
                PH_DUMP: begin
                    r_addr  <= i_ret_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                end
                default: begin
                    r_addr  <= '0;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                end
            endcase
        end
    end

    assign o_bram_addr  = r_addr;
    assign o_bram_wen   = r_wen;
    assign o_bram_wdata = r_wdata;

endmodule

// File: rtl/ds_job_sequencer.sv
// ds_job_sequencer
// Runs one image job at a time: LOAD (UART Rx bytes into BRAM), PROC (the
// downsampler core owns the BRAM, guarded by a watchdog), DUMP (retriever
// streams the BRAM out). Owns the single BRAM port through bram_port_mux.
// IMG_WORDS must not exceed 2**ADDR_W; PROC_TMO must be at least 2.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_go_n                   job request (active low), honoured only in IDLE
//   i_rx_valid, i_rx_data    UART Rx byte strobe and data
//   o_proc_start             one-cycle pulse starting the core
//   i_proc_done              core finished (first high cycle counts)
//   i_proc_addr/wen/wdata    core BRAM request
//   o_ret_start_n            one-cycle active-low retriever start
//   i_ret_addr, i_ret_fin    retriever read address and finish flag
//   o_bram_addr/wen/wdata    registered BRAM port
//   o_phase                  current phase (IDLE=0 LOAD=1 PROC=2 DUMP=3)
//   o_job_done               one-cycle pulse on DUMP->IDLE
//   o_err                    sticky error, cleared by the next accepted go

module ds_job_sequencer
    import ds_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IMG_WORDS = 65536,
    parameter int PROC_TMO  = 16777216
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go_n,
    input  logic              i_rx_valid,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_proc_start,
    input  logic              i_proc_done,
    input  logic [ADDR_W-1:0] i_proc_addr,
    input  logic              i_proc_wen,
    input  logic [DATA_W-1:0] i_proc_wdata,
    output logic              o_ret_start_n,
    input  logic [ADDR_W-1:0] i_ret_addr,
    input  logic              i_ret_fin,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_wen,
    output logic [DATA_W-1:0] o_bram_wdata,
    output logic [1:0]        o_phase,
    output logic              o_job_done,
    output logic              o_err
);

    // The load counter is one bit wider than the address so it can hold
    // IMG_WORDS itself after the final byte without wrapping.
    localparam int LOAD_W = ADDR_W + 1;
    localparam int TMO_W  = (PROC_TMO > 1) ? $clog2(PROC_TMO) : 1;
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(IMG_WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(PROC_TMO - 1);

    phase_t            r_state;
    phase_t            w_next;
    logic [LOAD_W-1:0] r_load_cnt;
    logic [LOAD_W-1:0] w_load_cnt_next;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [TMO_W-1:0]  w_tmo_next;
    logic              r_err;
    logic              w_err_next;
    logic              r_proc_start;
    logic              w_proc_start_next;
    logic              r_ret_start_n;
    logic              w_ret_start_n_next;
    logic              r_job_done;
    logic              w_job_done_next;
    logic              w_flush;

    // State and all control registers; every output pulse is registered so
    // it appears the cycle after the event that caused it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= PH_IDLE;
            r_load_cnt    <= '0;
            r_tmo_cnt     <= '0;
            r_err         <= 1'b0;
            r_proc_start  <= 1'b0;
            r_ret_start_n <= 1'b1;
            r_job_done    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_load_cnt    <= w_load_cnt_next;
            r_tmo_cnt     <= w_tmo_next;
            r_err         <= w_err_next;
            r_proc_start  <= w_proc_start_next;
            r_ret_start_n <= w_ret_start_n_next;
            r_job_done    <= w_job_done_next;
        end
    end

    // Next-state and pulse decode. The watchdog counter only runs while in
    // PROC and is zero everywhere else, so each PROC entry gets a full
    // PROC_TMO-cycle budget. proc_done is tested before the timeout so it
    // wins when both land on the same cycle.
    always_comb begin
        w_next             = r_state;
        w_load_cnt_next    = r_load_cnt;
        w_tmo_next         = '0;
        w_err_next         = r_err;
        w_proc_start_next  = 1'b0;
        w_ret_start_n_next = 1'b1;
        w_job_done_next    = 1'b0;
        w_flush            = 1'b0;

        case (r_state)
            PH_IDLE: begin
                if (!i_go_n) begin
                    w_next          = PH_LOAD;
                    w_load_cnt_next = '0;
                    w_err_next      = 1'b0;
                end
            end
            PH_LOAD: begin
                if (i_rx_valid) begin
                    w_load_cnt_next = r_load_cnt + LOAD_W'(1);
                    if (r_load_cnt == LOAD_LAST) begin
                        w_next            = PH_PROC;
                        w_proc_start_next = 1'b1;
                    end
                end
            end
            PH_PROC: begin
                if (i_proc_done) begin
                    w_next             = PH_DUMP;
                    w_ret_start_n_next = 1'b0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_next     = PH_IDLE;
                    w_err_next = 1'b1;
                    w_flush    = 1'b1;
                end else begin
                    w_tmo_next = r_tmo_cnt + TMO_W'(1);
                end
            end
            PH_DUMP: begin
                if (i_ret_fin) begin
                    w_next          = PH_IDLE;
                    w_job_done_next = 1'b1;
                end
            end
            default: begin
                w_next = PH_IDLE;
            end
        endcase

        // A byte arriving outside LOAD has nowhere to go; flag it. This
        // deliberately overrides the clear from a go accepted the same cycle.
        if (i_rx_valid && (r_state != PH_LOAD)) begin
            w_err_next = 1'b1;
        end
    end

    bram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram_port_mux (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sel        (r_state),
        .i_flush      (w_flush),
        .i_rx_addr    (r_load_cnt[ADDR_W-1:0]),
        .i_rx_wen     (i_rx_valid),
        .i_rx_wdata   (i_rx_data),
        .i_proc_addr  (i_proc_addr),
        .i_proc_wen   (i_proc_wen),
        .i_proc_wdata (i_proc_wdata),
        .i_ret_addr   (i_ret_addr),
        .o_bram_addr  (o_bram_addr),
        .o_bram_wen   (o_bram_wen),
        .o_bram_wdata (o_bram_wdata)
    );

    assign o_phase       = r_state;
    assign o_proc_start  = r_proc_start;
    assign o_ret_start_n = r_ret_start_n;
    assign o_job_done    = r_job_done;
    assign o_err         = r_err;

endmodule

// File: tb/tb_ds_job_sequencer.sv
// tb_ds_job_sequencer
// Directed bench for ds_job_sequencer with a 4-byte image and a 16-cycle
// watchdog so every phase and the abort path are reached quickly.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, so each check sees the result of the edge just taken.

module tb_ds_job_sequencer;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int IMG_WORDS = 4;
    localparam int PROC_TMO  = 16;

    logic              clk;
    logic              rstN;
    logic              goN;
    logic              rxValid;
    logic [DATA_W-1:0] rxData;
    logic              procStart;
    logic              procDone;
    logic [ADDR_W-1:0] procAddr;
    logic              procWen;
    logic [DATA_W-1:0] procWdata;
    logic              retStartN;
    logic [ADDR_W-1:0] retAddr;
    logic              retFin;
    logic [ADDR_W-1:0] bramAddr;
    logic              bramWen;
    logic [DATA_W-1:0] bramWdata;
    logic [1:0]        phase;
    logic              jobDone;
    logic              err;

    int assertCount = 0;
    int failCount   = 0;

    ds_job_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IMG_WORDS (IMG_WORDS),
        .PROC_TMO  (PROC_TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_go_n        (goN),
        .i_rx_valid    (rxValid),
        .i_rx_data     (rxData),
        .o_proc_start  (procStart),
        .i_proc_done   (procDone),
        .i_proc_addr   (procAddr),
        .i_proc_wen    (procWen),
        .i_proc_wdata  (procWdata),
        .o_ret_start_n (retStartN),
        .i_ret_addr    (retAddr),
        .i_ret_fin     (retFin),
        .o_bram_addr   (bramAddr),
        .o_bram_wen    (bramWen),
        .o_bram_wdata  (bramWdata),
        .o_phase       (phase),
        .o_job_done    (jobDone),
        .o_err         (err)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance the given number of rising edges, stopping just after the last.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstN = 1'b0; goN = 1'b1; rxValid = 1'b0; rxData = '0;
        procDone = 1'b0; procAddr = '0; procWen = 1'b0; procWdata = '0;
        retAddr = '0; retFin = 1'b0;
        applyStimulus(2);

        $display("[TB] reset state");
        checkOutput("rst_phase", phase, 0);
        checkOutput("rst_wen", bramWen, 0);
        checkOutput("rst_addr", bramAddr, 0);
        checkOutput("rst_ret_start_n", retStartN, 1);
        checkOutput("rst_proc_start", procStart, 0);
        checkOutput("rst_job_done", jobDone, 0);
        checkOutput("rst_err", err, 0);

        $display("[TB] load four bytes");
        rstN = 1'b1;
        applyStimulus(1);
        goN = 1'b0;
        applyStimulus(1);
        goN = 1'b1;
        checkOutput("go_phase", phase, 1);
        for (int i = 0; i < 4; i++) begin
            rxValid = 1'b1;
            rxData  = 8'hA0 + 8'(i);
            applyStimulus(1);
            checkOutput("load_wen", bramWen, 1);
            checkOutput("load_addr", bramAddr, i);
            checkOutput("load_wdata", bramWdata, 32'hA0 + i);
            checkOutput("load_proc_start", procStart, (i == 3) ? 1 : 0);
            checkOutput("load_phase", phase, (i == 3) ? 2 : 1);
            rxValid = 1'b0;
            applyStimulus(1);
            checkOutput("load_gap_wen", bramWen, 0);
            checkOutput("load_gap_proc_start", procStart, 0);
        end

        $display("[TB] core owns the port");
        procAddr = 16'h0010; procWen = 1'b1; procWdata = 8'h5A;
        applyStimulus(1);
        checkOutput("proc_addr", bramAddr, 16'h0010);
        checkOutput("proc_wen", bramWen, 1);
        checkOutput("proc_wdata", bramWdata, 8'h5A);
        procDone = 1'b1;
        applyStimulus(1);
        procDone = 1'b0;
        checkOutput("done_phase", phase, 3);
        checkOutput("done_ret_start_n", retStartN, 0);
        applyStimulus(1);
        checkOutput("dump_ret_start_n_back", retStartN, 1);
        checkOutput("dump_wen_forced", bramWen, 0);

        $display("[TB] retriever sweep");
        for (int a = 0; a < 4; a++) begin
            retAddr = 16'(a);
            applyStimulus(1);
            checkOutput("dump_addr", bramAddr, a);
            checkOutput("dump_wen", bramWen, 0);
        end
        retFin = 1'b1;
        applyStimulus(1);
        retFin = 1'b0;
        checkOutput("fin_phase", phase, 0);
        checkOutput("fin_job_done", jobDone, 1);
        checkOutput("fin_ret_start_n", retStartN, 1);
        applyStimulus(1);
        checkOutput("fin_job_done_pulse", jobDone, 0);
        checkOutput("fin_ret_start_n_hold", retStartN, 1);
        checkOutput("fin_err", err, 0);

        $display("[TB] watchdog abort");
        procWen = 1'b0;
        goN = 1'b0;
        applyStimulus(1);
        goN = 1'b1;
        rxValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rxData = 8'hB0 + 8'(i);
            applyStimulus(1);
        end
        rxValid = 1'b0;
        checkOutput("tmo_enter_phase", phase, 2);
        procWen = 1'b1;
        applyStimulus(PROC_TMO - 1);
        checkOutput("tmo_still_proc", phase, 2);
        checkOutput("tmo_wen_before", bramWen, 1);
        checkOutput("tmo_err_before", err, 0);
        applyStimulus(1);
        checkOutput("tmo_phase", phase, 0);
        checkOutput("tmo_err", err, 1);
        checkOutput("tmo_wen_flushed", bramWen, 0);
        checkOutput("tmo_ret_start_n", retStartN, 1);
        procWen = 1'b0;
        applyStimulus(1);
        checkOutput("tmo_err_sticky", err, 1);
        goN = 1'b0;
        applyStimulus(1);
        goN = 1'b1;
        checkOutput("go_clears_err", err, 0);
        checkOutput("go_after_tmo_phase", phase, 1);

        $display("[TB] reset mid-load");
        for (int i = 0; i < 2; i++) begin
            rxValid = 1'b1;
            rxData  = 8'hD0 + 8'(i);
            applyStimulus(1);
            checkOutput("rl_addr", bramAddr, i);
        end
        rstN = 1'b0;
        rxData = 8'hEE;
        applyStimulus(1);
        rstN = 1'b1;
        rxValid = 1'b0;
        checkOutput("rl_phase", phase, 0);
        checkOutput("rl_wen", bramWen, 0);
        checkOutput("rl_err", err, 0);

        $display("[TB] dropped byte and ignored go");
        rxValid = 1'b1;
        rxData  = 8'h77;
        applyStimulus(1);
        rxValid = 1'b0;
        checkOutput("idle_rx_err", err, 1);
        checkOutput("idle_rx_wen", bramWen, 0);
        checkOutput("idle_rx_phase", phase, 0);
        goN = 1'b0;
        applyStimulus(1);
        checkOutput("restart_phase", phase, 1);
        checkOutput("restart_err", err, 0);
        rxValid = 1'b1;
        rxData  = 8'hC0;
        applyStimulus(1);
        goN = 1'b1;
        checkOutput("restart_addr0", bramAddr, 0);
        checkOutput("restart_wen", bramWen, 1);
        checkOutput("restart_wdata", bramWdata, 8'hC0);
        checkOutput("load_go_phase", phase, 1);
        for (int i = 1; i < 4; i++) begin
            rxData = 8'hC0 + 8'(i);
            applyStimulus(1);
            checkOutput("restart_addr", bramAddr, i);
        end
        rxValid = 1'b0;
        checkOutput("restart_proc_phase", phase, 2);
        checkOutput("restart_proc_start", procStart, 1);
        checkOutput("restart_err_clean", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
